// File: rtl/mux_rr.sv
// mux_rr: N-channel registered multiplexer, fixed-select or round-robin among valid channels.
// Latency: 1 cycle from input handshake to out_valid; sustains 1 word/cycle.
// Backpressure: out_valid=1 with out_ready=0 drops every in_ready and freezes output and pointer.
module mux_rr #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  // Index of the most recently granted channel in round-robin mode; searched last.
  logic [SEL_W-1:0]  last;
  logic [NUM_CH-1:0] grant;
  logic              found;
  logic              can_accept;
  logic              xfer_in;
  logic [SEL_W-1:0]  gidx;
  logic [WIDTH-1:0]  gdata;

  // The output register can take a word when empty or when it is being drained this cycle.
  assign can_accept = !out_valid || out_ready;

  // Arbitration: direct select in fixed mode (out-of-range sel grants nothing),
  // otherwise first valid channel starting just after the last one served.
  always_comb begin
    grant = '0;
    found = 1'b0;
    if (!mode) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (int'(sel) == i) begin
          grant[i] = in_valid[i];
        end
      end
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (!found && in_valid[i] && (((int'(last) + k) % NUM_CH) == i)) begin
            grant[i] = 1'b1;
            found    = 1'b1;
          end
        end
      end
    end
  end

  // Encode the one-hot grant into a channel index and pick that channel's data.
  always_comb begin
    gidx  = '0;
    gdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        gidx  = SEL_W'(i);
        gdata = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready = grant & {NUM_CH{can_accept}};
  assign xfer_in  = |(in_valid & in_ready);

  // Output register and round-robin pointer; capture has priority over a plain drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      last      <= SEL_W'(NUM_CH - 1);
    end else if (xfer_in) begin
      out_valid <= 1'b1;
      out_data  <= gdata;
      out_ch    <= gidx;
      if (mode) begin
        last <= gidx;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr.sv
// tb_mux_rr: directed bench for mux_rr with an expected-word queue checked by an output monitor.
// Latency: stimulus changes #1 after posedge, checks #2 after posedge, monitor samples on negedge.
// Backpressure: words are popped only when out_valid and out_ready are both high.
module tb_mux_rr;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [SEL_W-1:0] c;
  } exp_t;

  logic                    clk;
  logic                    rst_n;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_valid;
  logic                    out_ready;

  exp_t exp_q[$];
  int   total;
  int   bad;

  mux_rr #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] d, input logic [SEL_W-1:0] c);
    exp_t e;
    e.d = d;
    e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every accepted output word must match the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL out_unexpected: got data=0x%0h ch=%0d with empty queue at %0t",
                   out_data, out_ch, $time);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.d || out_ch !== e.c) begin
            bad++;
            $display("FAIL out_word: got data=0x%0h ch=%0d, expected data=0x%0h ch=%0d at %0t",
                     out_data, out_ch, e.d, e.c, $time);
          end
        end
      end
    end
  end

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = '0;
    in_data   = {8'h43, 8'h32, 8'h21, 8'h10};
    in_valid  = '0;
    out_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'h00);
    chk("rst_ch", 32'(out_ch), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'b0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin, all valid: 0,1,2,3,0 back to back
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    push(8'h10, 2'd0);
    push(8'h21, 2'd1);
    push(8'h32, 2'd2);
    push(8'h43, 2'd3);
    push(8'h10, 2'd0);
    repeat (5) tick();
    in_valid = 4'b0000;
    tick();
    #1;
    chk("rr_drain_valid", 32'(out_valid), 32'd0);

    // Fixed select sel=2, then sel=1
    mode     = 1'b0;
    sel      = 2'd2;
    in_valid = 4'b1111;
    #1;
    chk("fix_ready", 32'(in_ready), 32'b0100);
    push(8'h32, 2'd2);
    push(8'h32, 2'd2);
    push(8'h32, 2'd2);
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      chk("fix_ready_run", 32'(in_ready), 32'b0100);
    end
    sel = 2'd1;
    push(8'h21, 2'd1);
    tick();

    // Back to round-robin: pointer retained at 0 through fixed mode, so channel 1 next
    mode = 1'b1;
    push(8'h21, 2'd1);
    tick();

    // Stall for 3 cycles with channel 1 word held
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_ready", 32'(in_ready), 32'b0000);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'h21);
      chk("stall_ch", 32'(out_ch), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    push(8'h32, 2'd2);
    push(8'h43, 2'd3);
    tick();
    tick();

    // Sparse round-robin with last=3: 1,3,1,3, then channel 0 joins and wins before 1
    in_valid = 4'b1010;
    push(8'h21, 2'd1);
    push(8'h43, 2'd3);
    push(8'h21, 2'd1);
    push(8'h43, 2'd3);
    repeat (4) tick();
    in_valid = 4'b1011;
    push(8'h10, 2'd0);
    push(8'h21, 2'd1);
    repeat (2) tick();

    // Drain without refill: output register empties, data holds
    in_valid = 4'b0000;
    tick();
    #1;
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_data", 32'(out_data), 32'h21);
    chk("drain_ch", 32'(out_ch), 32'd1);

    // Asynchronous reset while a word is held (pointer is 1 here)
    in_valid = 4'b1111;
    push(8'h32, 2'd2);
    tick();
    tick();
    // channel 3 word is now registered and will be discarded by reset
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", 32'(out_data), 32'h00);
    chk("arst_ch", 32'(out_ch), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'b0001);
    #1;
    rst_n = 1'b1;
    push(8'h10, 2'd0);
    push(8'h21, 2'd1);
    tick();
    tick();
    in_valid = 4'b0000;
    tick();
    tick();
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
